// File: rtl/key_exp_inv.sv
// AES-128 inverse key expansion: round key n in, round key n-1 out, one byte per cycle.
// Build option KEY_EXP_INV_CHAIN_EN: keep stepping back to round key 0 without reloading.
module key_exp_inv (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       enable_din,
  input  logic [3:0] rnd,
  output logic [7:0] addr_out,
  output logic       enable_sbox,
  input  logic [7:0] sbox_in,
  input  logic       round_complete,
  output logic [7:0] dout,
  output logic       enable_out,
  output logic       busy
);
  localparam int unsigned NB   = 16;
  localparam int unsigned CW   = 4;
  localparam int unsigned NREQ = 4;

  typedef enum logic [2:0] {LOAD, XOR, SBOX, COL0, WAIT, OUT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [3:0]    rnd_q;
  logic [7:0]    key   [NB];
  logic [7:0]    s_buf [NREQ];
  logic [7:0]    addr_d, dout_d;
  logic          enable_sbox_d, enable_out_d;
  logic          last_round_c;
  logic [1:0]    rot_row_c;
  logic [7:0]    rcon_c;

  function automatic logic [7:0] rcon_of(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign rcon_c    = rcon_of(rnd_q);
  // RotWord: request r reads row r+1 of word 3
  assign rot_row_c = cnt[1:0] + 2'd1;

`ifdef KEY_EXP_INV_CHAIN_EN
  assign last_round_c = (rnd_q <= 4'd1);
`else
  assign last_round_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD;
      cnt         <= '0;
      addr_out    <= 8'h00;
      enable_sbox <= 1'b0;
      dout        <= 8'h00;
      enable_out  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      addr_out    <= addr_d;
      enable_sbox <= enable_sbox_d;
      dout        <= dout_d;
      enable_out  <= enable_out_d;
      busy        <= (next_state != LOAD);
    end
  end

  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    addr_d        = addr_out;
    enable_sbox_d = 1'b0;
    dout_d        = dout;
    enable_out_d  = 1'b0;
    unique case (state)
      LOAD: begin
        if (enable_din) begin
          next_cnt = cnt + CW'(1);
          if (cnt == CW'(NB - 1)) next_state = XOR;
        end
      end
      XOR: begin
        next_state = SBOX;
        next_cnt   = '0;
      end
      SBOX: begin
        // cnt 0..3 issue requests; results land during cnt 2..5
        next_cnt = cnt + CW'(1);
        if (cnt < CW'(NREQ)) begin
          enable_sbox_d = 1'b1;
          addr_d        = key[{rot_row_c, 2'b11}];
        end
        if (cnt == CW'(NREQ + 1)) begin
          next_state = COL0;
          next_cnt   = '0;
        end
      end
      COL0: next_state = WAIT;
      WAIT: begin
        if (round_complete) begin
          next_state = OUT;
          next_cnt   = '0;
        end
      end
      OUT: begin
        enable_out_d = 1'b1;
        dout_d       = key[cnt];
        next_cnt     = cnt + CW'(1);
        if (cnt == CW'(NB - 1)) next_state = last_round_c ? LOAD : XOR;
      end
      default: begin
        next_state = LOAD;
        next_cnt   = '0;
      end
    endcase
  end

  // Key storage is updated in place; it ends up holding the previous round key.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == LOAD && enable_din) begin
        key[cnt] <= din;
        if (cnt == '0) rnd_q <= rnd;
      end
      if (state == XOR) begin
        for (int unsigned r = 0; r < 4; r++) begin
          for (int unsigned c = 1; c < 4; c++) begin
            key[CW'(4*r + c)] <= key[CW'(4*r + c)] ^ key[CW'(4*r + c - 1)];
          end
        end
      end
      if (state == SBOX && cnt >= CW'(2)) s_buf[2'(cnt - CW'(2))] <= sbox_in;
      if (state == COL0) begin
        for (int unsigned r = 0; r < 4; r++) begin
          key[CW'(4*r)] <= key[CW'(4*r)] ^ s_buf[2'(r)] ^ ((r == 0) ? rcon_c : 8'h00);
        end
      end
      if (state == OUT && cnt == CW'(NB - 1) && !last_round_c) rnd_q <= rnd_q - 4'd1;
    end
  end

endmodule
